// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: issues BRAM reads ahead of decode and
// buffers returned words with their PCs in a small show-ahead queue.
module fetch_prefetch_queue #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 4,
    parameter int              MEM_LATENCY = 1,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_flush,
    input  logic [XLEN-1:0]          c_pc,
    output logic [XLEN-1:0]          i_addr,
    input  logic [31:0]              i_data,
    output logic                     i_clk,
    output logic                     i_en,
    output logic                     i_we,
    output logic                     o_valid,
    input  logic                     o_next,
    output logic [31:0]              o_inst,
    output logic [XLEN-1:0]          o_pc,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = LW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic            tag_v  [MEM_LATENCY];
    logic [XLEN-1:0] tag_pc [MEM_LATENCY];
    logic [31:0]     q_inst [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   used;
    logic            push;
    logic            pop;

    assign i_clk  = clk;
    assign i_we   = 1'b0;
    assign i_addr = fetch_pc;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            in_flight = in_flight + CW'(tag_v[i]);
        end
    end

    // Credit: queued plus outstanding words never exceed the queue size.
    assign used = CW'(count) + in_flight;
    assign i_en = !rst && !c_flush && (used < DEPTH_C);

    assign o_valid = (count != '0);
    assign o_level = count;
    assign o_inst  = o_valid ? q_inst[rd_ptr] : '0;
    assign o_pc    = o_valid ? q_pc[rd_ptr] : '0;

    assign push = tag_v[MEM_LATENCY-1] && !c_flush;
    assign pop  = o_valid && o_next && !c_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (c_flush) begin
            fetch_pc <= {c_pc[XLEN-1:2], 2'b00};
        end else if (i_en) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || c_flush) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_v[i] <= 1'b0;
            end
        end else begin
            tag_v[0] <= i_en;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_pc[0] <= fetch_pc;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_pc[i] <= tag_pc[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= i_data;
            q_pc[wr_ptr]   <= tag_pc[MEM_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || c_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: two instances (latency 1 and latency 3
// with a wrapping reset PC) share stimulus, each with its own scoreboard.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_flush;
    logic [31:0] c_pc;
    logic        o_next;

    logic [31:0] a_addr, a_data, a_inst, a_pc;
    logic        a_iclk, a_en, a_we, a_valid;
    logic [2:0]  a_level;
    logic [31:0] b_addr, b_data, b_inst, b_pc;
    logic        b_iclk, b_en, b_we, b_valid;
    logic [2:0]  b_level;

    logic [31:0] b_d1, b_d2;
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    logic [31:0] a_mpc, b_mpc, e;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .XLEN(32), .DEPTH(4), .MEM_LATENCY(1), .RESET_PC(32'h0)
    ) u_a (
        .clk(clk), .rst(rst), .c_flush(c_flush), .c_pc(c_pc),
        .i_addr(a_addr), .i_data(a_data), .i_clk(a_iclk),
        .i_en(a_en), .i_we(a_we), .o_valid(a_valid), .o_next(o_next),
        .o_inst(a_inst), .o_pc(a_pc), .o_level(a_level)
    );

    fetch_prefetch_queue #(
        .XLEN(32), .DEPTH(4), .MEM_LATENCY(3), .RESET_PC(32'hFFFF_FFF8)
    ) u_b (
        .clk(clk), .rst(rst), .c_flush(c_flush), .c_pc(c_pc),
        .i_addr(b_addr), .i_data(b_data), .i_clk(b_iclk),
        .i_en(b_en), .i_we(b_we), .o_valid(b_valid), .o_next(o_next),
        .o_inst(b_inst), .o_pc(b_pc), .o_level(b_level)
    );

    function automatic logic [31:0] memval(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Block RAM models with 1 and 3 cycle read latency.
    always @(posedge a_iclk) a_data <= memval(a_addr);
    always @(posedge b_iclk) begin
        b_d1   <= memval(b_addr);
        b_d2   <= b_d1;
        b_data <= b_d2;
    end

    always @(negedge clk) begin
        if (rst) begin
            a_q.delete();
            a_mpc = 32'h0;
        end else if (c_flush) begin
            check("a_flush_en", 32'(a_en), 32'd0);
            a_q.delete();
            a_mpc = {c_pc[31:2], 2'b00};
        end else begin
            if (a_valid && o_next) begin
                if (a_q.size() == 0) begin
                    check("a_sb_empty", a_pc, 32'hFFFF_FFFF);
                end else begin
                    e = a_q.pop_front();
                    check("a_pop_pc", a_pc, e);
                    check("a_pop_inst", a_inst, memval(e));
                end
            end
            if (a_en) begin
                check("a_issue_addr", a_addr, a_mpc);
                a_q.push_back(a_mpc);
                a_mpc = a_mpc + 32'd4;
            end
            check("a_level_max", 32'(a_level <= 3'd4), 32'd1);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_q.delete();
            b_mpc = 32'hFFFF_FFF8;
        end else if (c_flush) begin
            check("b_flush_en", 32'(b_en), 32'd0);
            b_q.delete();
            b_mpc = {c_pc[31:2], 2'b00};
        end else begin
            if (b_valid && o_next) begin
                if (b_q.size() == 0) begin
                    check("b_sb_empty", b_pc, 32'hFFFF_FFFF);
                end else begin
                    e = b_q.pop_front();
                    check("b_pop_pc", b_pc, e);
                    check("b_pop_inst", b_inst, memval(e));
                end
            end
            if (b_en) begin
                check("b_issue_addr", b_addr, b_mpc);
                b_q.push_back(b_mpc);
                b_mpc = b_mpc + 32'd4;
            end
            check("b_level_max", 32'(b_level <= 3'd4), 32'd1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; c_flush = 1'b0; c_pc = '0; o_next = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_a_level", 32'(a_level), 32'd0);
        check("rst_a_en", 32'(a_en), 32'd0);
        check("rst_a_we", 32'(a_we), 32'd0);
        check("rst_a_inst", a_inst, 32'd0);
        check("rst_a_pc", a_pc, 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_b_we", 32'(b_we), 32'd0);

        // Fill with the consumer stalled.
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            rst = 1'b0;
            @(negedge clk);
            if (c < 4) begin
                check("fill_a_en", 32'(a_en), 32'd1);
                check("fill_a_addr", a_addr, 32'(4 * c));
                check("fill_b_en", 32'(b_en), 32'd1);
                check("fill_b_addr", b_addr, 32'hFFFF_FFF8 + 32'(4 * c));
            end
            if (c == 2) begin
                check("first_a_valid", 32'(a_valid), 32'd1);
                check("first_a_inst", a_inst, 32'h1000_0000);
                check("first_a_pc", a_pc, 32'd0);
            end
            if (c == 3) check("b_not_yet", 32'(b_valid), 32'd0);
            if (c == 4) begin
                check("stall_a_en", 32'(a_en), 32'd0);
                check("stall_b_en", 32'(b_en), 32'd0);
                check("first_b_valid", 32'(b_valid), 32'd1);
                check("first_b_pc", b_pc, 32'hFFFF_FFF8);
                check("first_b_inst", b_inst, memval(32'hFFFF_FFF8));
            end
            if (c == 5) check("full_a_level", 32'(a_level), 32'd4);
            if (c == 7) check("full_b_level", 32'(b_level), 32'd4);
        end

        // Backpressure 1,0,0 then flush with 3 queued and 1 in flight.
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            o_next  = (k % 3 == 0) || (k == 8);
            c_flush = (k == 8);
            c_pc    = 32'h103;
            @(negedge clk);
            if (k < 8) check("bp_a_en", 32'(a_en), 32'(k % 3 == 1));
            if (k == 8) check("pre_flush_level", 32'(a_level), 32'd3);
        end

        for (int f = 1; f < 5; f++) begin
            next_cycle();
            c_flush = 1'b0;
            o_next  = 1'b0;
            @(negedge clk);
            if (f == 1) begin
                check("fl_a_valid", 32'(a_valid), 32'd0);
                check("fl_a_level", 32'(a_level), 32'd0);
                check("fl_a_addr", a_addr, 32'h100);
                check("fl_a_en", 32'(a_en), 32'd1);
                check("fl_b_addr", b_addr, 32'h100);
            end
            if (f == 3) begin
                check("fl_first_valid", 32'(a_valid), 32'd1);
                check("fl_first_pc", a_pc, 32'h100);
                check("fl_first_inst", a_inst, 32'h1000_0040);
            end
        end

        // Sustained streaming.
        for (int s = 0; s < 20; s++) begin
            next_cycle();
            o_next = 1'b1;
            @(negedge clk);
            check("stream_a_valid", 32'(a_valid), 32'd1);
            if (s == 0) begin
                check("fl_b_valid", 32'(b_valid), 32'd1);
                check("fl_b_pc", b_pc, 32'h100);
            end
        end

        // Reset mid-stream, then flush while latency-3 reads are in flight.
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_a_en", 32'(a_en), 32'd0);
        check("mid_rst_b_en", 32'(b_en), 32'd0);
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            rst     = 1'b0;
            c_flush = (c == 3);
            c_pc    = 32'h200;
            @(negedge clk);
            if (c == 0) begin
                check("mid_rst_a_valid", 32'(a_valid), 32'd0);
                check("mid_rst_a_level", 32'(a_level), 32'd0);
                check("mid_rst_b_addr", b_addr, 32'hFFFF_FFF8);
            end
            if (c == 3) check("b3_level", 32'(b_level), 32'd0);
            if (c == 4) check("b3_addr", b_addr, 32'h200);
            if (c >= 4 && c <= 7) check("b3_drop", 32'(b_valid), 32'd0);
            if (c == 8) begin
                check("b3_valid", 32'(b_valid), 32'd1);
                check("b3_pc", b_pc, 32'h200);
                check("b3_inst", b_inst, 32'h1000_0080);
            end
        end

        c_flush = 1'b0;
        repeat (10) next_cycle();
        o_next = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
